// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                fetch state encoding, NOP word and sequential PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // FETCH: request outstanding, HOLD: word parked for decode,
    // DRAIN: a stale request is still in flight and its response is dropped.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 - presented on instr while nothing has been fetched.
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    // Sequential fetch advances by one 32-bit instruction word.
    localparam logic [31:0] c_PC_INC = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selection. Computes the sequential
//                PC+4 and the redirect target (base + immediate), then picks
//                redirect > advance > hold. All sums wrap modulo 2^DW.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import fetch_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_pc,
    input  logic          i_redirect,
    input  logic [DW-1:0] i_base,
    input  logic [DW-1:0] i_imm,
    input  logic          i_advance,
    output logic [DW-1:0] o_pc_next
);

    logic [DW-1:0] w_pc_plus;
    logic [DW-1:0] w_target;

    // Both candidates are plain modular adds; no alignment fix-up on the target.
    assign w_pc_plus = i_pc + DW'(c_PC_INC);
    assign w_target  = i_base + i_imm;

    // A taken branch always wins; otherwise step only when a word was accepted.
    always_comb begin
        o_pc_next = i_pc;
        if (i_redirect) begin
            o_pc_next = w_target;
        end else if (i_advance) begin
            o_pc_next = w_pc_plus;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Single-outstanding-request instruction fetch stage. Issues a
//                level request at PC, parks the returned word for decode,
//                and handles branch redirects including dropping a response
//                that belongs to a request made before the redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int            DW       = 32,
    parameter logic [DW-1:0] RESET_PC = DW'(32'h0000_0000)
) (
    input  logic          clk,
    input  logic          rst,
    // instruction memory
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_valid,
    // decode side
    output logic [DW-1:0] instr,
    output logic [DW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    // branch resolution
    input  logic          redirect,
    input  logic [DW-1:0] redirect_base,
    input  logic [DW-1:0] ImmOp
);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] w_pc_next;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_instr_pc;
    logic          w_load;

    // Next-PC arithmetic lives in its own combinational block.
    pc_next_sel #(
        .DW (DW)
    ) u_pc_next_sel (
        .i_pc       (r_pc),
        .i_redirect (redirect),
        .i_base     (redirect_base),
        .i_imm      (ImmOp),
        .i_advance  (w_load),
        .o_pc_next  (w_pc_next)
    );

    // State register; reset restarts fetching at RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC and the held instruction word; the word only changes on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= DW'(c_NOP);
            r_instr_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
            if (w_load) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    // Next-state and output decode; outputs depend on the state register only.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // A response landing with the redirect is for the old path.
                    w_state_next = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                // Stray imem_valid here is a protocol violation and is ignored.
                if (redirect || instr_ready) begin
                    w_state_next = FETCH;
                end
            end
            DRAIN: begin
                if (imem_valid) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign instr_pc  = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed scenarios
//                followed by randomized traffic against a behavioural model
//                and a small instruction-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [31:0] ImmOp = '0;

    fetch_stage #(
        .DW       (32),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_base (redirect_base),
        .ImmOp         (ImmOp)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Behavioural model: what the stage holds, in terms of pending work.
    bit          m_init  = 1'b0;
    bit          m_have  = 1'b0;   // a fetched word waits for decode
    bit          m_stale = 1'b0;   // an abandoned request's response is due
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_ipc   = '0;

    // Memory responder state.
    bit mem_busy = 1'b0;
    int mem_cnt  = 0;
    int lat_lo   = 0;
    int lat_hi   = 0;
    bit junk_en  = 1'b0;

    // Outputs observed at the most recent step.
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_ivalid;
    logic [31:0] obs_instr;

    logic [31:0] seq_pc[$];
    int          seq_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_req();
        return m_init && !m_have && !m_stale;
    endfunction

    function automatic bit is_accept();
        return exp_req() && !mem_busy;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [31:0] d,
                              input bit rd, input logic [31:0] tgt, input bit rdy);
        if (r) begin
            m_init = 1'b1; m_have = 1'b0; m_stale = 1'b0;
            m_pc = c_RESET_PC; m_instr = 32'h0000_0013; m_ipc = c_RESET_PC;
        end else if (m_have) begin
            if (rd) begin
                m_pc = tgt; m_have = 1'b0;
            end else if (rdy) begin
                m_have = 1'b0;
            end
        end else if (m_stale) begin
            if (rd) m_pc = tgt;
            if (v)  m_stale = 1'b0;
        end else begin
            if (rd) begin
                m_pc = tgt;
                if (!v) m_stale = 1'b1;
            end else if (v) begin
                m_instr = d; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_have = 1'b1;
            end
        end
    endtask

    // One clock cycle: compare outputs, play memory, drive inputs, advance model.
    task automatic step(input bit t_rst, input bit t_redir, input logic [31:0] t_base,
                        input logic [31:0] t_imm, input bit t_ready);
        bit          v;
        logic [31:0] d;
        @(negedge clk);
        obs_req = imem_req; obs_addr = imem_addr; obs_ivalid = instr_valid; obs_instr = instr;
        if (m_init) begin
            check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
            if (exp_req()) check_eq("imem_addr", imem_addr, m_pc);
            check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            check_eq("instr", instr, m_instr);
            check_eq("instr_pc", instr_pc, m_ipc);
            if (instr_valid && t_ready) begin
                seq_pc.push_back(instr_pc);
                seq_cyc.push_back(cyc);
            end
        end
        v = 1'b0;
        d = $urandom;
        if (t_rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin v = 1'b1; mem_busy = 1'b0; end
        end else if (exp_req()) begin
            mem_cnt = $urandom_range(lat_hi, lat_lo);
            if (mem_cnt == 0) v = 1'b1;
            else mem_busy = 1'b1;
        end else if (junk_en && m_have && $urandom_range(0, 9) == 0) begin
            v = 1'b1;   // stray strobe while a word is held
        end
        rst = t_rst; imem_valid = v; imem_rdata = d;
        redirect = t_redir; redirect_base = t_base; ImmOp = t_imm; instr_ready = t_ready;
        model_step(t_rst, v, d, t_redir, t_base + t_imm, t_ready);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n;
        // Reset
        lat_lo = 0; lat_hi = 0;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_eq("rst_ivalid", {31'b0, obs_ivalid}, 32'd0);
        check_eq("rst_instr", obs_instr, 32'h0000_0013);

        // Zero-wait streaming with decode always ready; start wraps past 2^32.
        seq_pc.delete(); seq_cyc.delete();
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("first_req", {31'b0, obs_req}, 32'd1);
        check_eq("first_addr", obs_addr, c_RESET_PC);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        check_eq("seq_len_ok", {31'b0, seq_pc.size() >= 4}, 32'd1);
        if (seq_pc.size() >= 4) begin
            check_eq("seq_pc0", seq_pc[0], 32'hFFFF_FFFC);
            check_eq("seq_pc1", seq_pc[1], 32'h0000_0000);
            check_eq("seq_pc2", seq_pc[2], 32'h0000_0004);
            check_eq("seq_pc3", seq_pc[3], 32'h0000_0008);
            check_eq("seq_gap1", seq_cyc[1] - seq_cyc[0], 32'd2);
            check_eq("seq_gap2", seq_cyc[2] - seq_cyc[1], 32'd2);
        end

        // Decode stalls for 5 cycles while a word is held.
        n = 0;
        while (!instr_valid && n < 10) begin step(1'b0, 1'b0, '0, '0, 1'b0); n++; end
        check_eq("hold_reached", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0);
            check_eq("hold_req_low", {31'b0, obs_req}, 32'd0);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1);

        // Redirect in FETCH, stale response 3 cycles later.
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!is_accept() && n < 10) begin step(1'b0, 1'b0, '0, '0, 1'b1); n++; end
        step(1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 1'b1);
        lat_lo = 0; lat_hi = 0;
        n = 0;
        do begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
            check_eq("drain_no_ivalid", {31'b0, obs_ivalid}, 32'd0);
            n++;
        end while (!obs_req && n < 10);
        check_eq("drain_new_addr", obs_addr, 32'h0000_00F0);

        // Redirect coinciding with a response.
        n = 0;
        while (!is_accept() && n < 10) begin step(1'b0, 1'b0, '0, '0, 1'b1); n++; end
        step(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0040, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check_eq("redir_same_req", {31'b0, obs_req}, 32'd1);
        check_eq("redir_same_addr", obs_addr, 32'h0000_0060);
        check_eq("redir_same_nohold", {31'b0, obs_ivalid}, 32'd0);

        // Reset while a word is held.
        n = 0;
        while (!instr_valid && n < 10) begin step(1'b0, 1'b0, '0, '0, 1'b0); n++; end
        check_eq("hold_before_rst", {31'b0, instr_valid}, 32'd1);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check_eq("rst_hold_ivalid", {31'b0, obs_ivalid}, 32'd0);
        check_eq("rst_hold_instr", obs_instr, 32'h0000_0013);
        check_eq("rst_hold_addr", obs_addr, c_RESET_PC);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 3; junk_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
